qtable_dump_ctrl: RTL
=====================

Name: qtable_dump_ctrl

Overview:
Sequences the end-of-run dump of the Q-table memory into the result file writer. On start it requests the Q-table read port from the learning core and walks every address in order. It forwards each read word to the writer's data/valid_in pair, then issues the one-cycle stop that closes the output file. It sits between the Q-table RAM, the learning-core port arbiter and the file writer.

Parameters:
DATA_WIDTH, 32, width of one Q-value word (matches writer data)
ADDR_WIDTH, 6, Q-table address width
NUM_ENTRIES, 64, entries to dump (1..2^ADDR_WIDTH)
RD_LATENCY, 1, RAM read latency in cycles (1..4)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
start  in  1  begin dump; sampled only in IDLE
hold  in  1  stall new read issue while 1
mem_req  out  1  request for Q-table read port
mem_gnt  in  1  port granted by learning core
mem_rd_en  out  1  read strobe
mem_addr  out  ADDR_WIDTH  read address
mem_rdata  in  DATA_WIDTH  read data, valid RD_LATENCY cycles after mem_rd_en
wr_data  out  DATA_WIDTH  word to file writer
wr_valid  out  1  writer valid_in
wr_stop  out  1  writer stop, one-cycle pulse
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse with wr_stop

Behaviour:
- Reset (async, rst=1): state IDLE; mem_req, mem_rd_en, wr_valid, wr_stop, busy, done = 0; mem_addr, wr_data = 0; read pipeline and in-flight counter cleared. Reset mid-dump aborts with no stop pulse.
- All outputs are registered.
- States: IDLE, REQ, READ, DRAIN, STOP.
- IDLE: start=1 -> REQ, mem_addr=0. start is ignored in every other state.
- REQ: mem_req=1. mem_gnt=1 -> READ.
- READ: mem_req=1. In any cycle with mem_gnt=1 and hold=0: mem_rd_en=1 at current mem_addr, then mem_addr increments. Otherwise mem_rd_en=0 and the address holds.
  - Issuing address NUM_ENTRIES-1 -> DRAIN.
  - mem_addr does not wrap: it stops at NUM_ENTRIES-1.
  - Losing mem_gnt mid-READ stalls issue only. Already-issued reads still complete.
- Read pipeline: RD_LATENCY-deep valid shift register fed by mem_rd_en. When its output is 1, wr_data <= mem_rdata and wr_valid <= 1 on the next edge. Latency from mem_rd_en to wr_valid = RD_LATENCY+1 cycles.
  - hold does not stall the pipeline, because the writer cannot back-pressure.
- In-flight counter: +1 on issue, -1 on wr_valid, both in the same cycle -> unchanged.
- DRAIN: mem_req=1, mem_rd_en=0. When the counter = 0 and no wr_valid is pending -> STOP.
- STOP: wr_stop=1 and done=1 for exactly one cycle, never in the same cycle as wr_valid. mem_req drops. -> IDLE.
- Data ordering: exactly NUM_ENTRIES wr_valid pulses per dump, in address order 0..NUM_ENTRIES-1. No duplicates, no gaps.
- A new start after IDLE re-runs the dump. Handling a stop on an already-closed file is the writer's concern.
- NUM_ENTRIES=1: one read, then DRAIN.

Test Plan:
- NUM_ENTRIES=8, RD_LATENCY=2, RAM[a]=3a+1, gnt tied 1, hold 0; pulse start -> mem_rd_en on 8 consecutive cycles for addr 0..7; wr_valid 3 cycles after each, data 1,4,7,...,22; wr_stop+done 1 cycle after last wr_valid; busy falls the same edge.
- Same config, hold=1 for cycles 3-5 of READ -> issue pauses for 3 cycles, in-flight data still emitted; total 8 words in order, no duplicates.
- mem_gnt held 0 for 10 cycles after start -> stays in REQ with mem_req=1 and no mem_rd_en; gnt=1 -> dump proceeds normally. gnt dropped after addr 4 for 5 cycles -> addrs 5..7 issued after regrant; words 0..7 emitted in order.
- rst asserted asynchronously mid-READ (after 3 words) -> all outputs 0 immediately, no wr_stop; a new start produces a full 8-word dump from addr 0.
- start pulsed again during READ and DRAIN -> ignored, exactly 8 words and one stop. NUM_ENTRIES=1, RD_LATENCY=4 -> single word RAM[0]=1 at 5 cycles after mem_rd_en, then stop.

Source files
------------

// File: rtl/qtable_dump_ctrl.sv
// Q-table end-of-run dump sequencer: walks every Q-table address through the
// granted read port and streams each word to the result file writer, then closes the file.
module qtable_dump_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 6,
  parameter int NUM_ENTRIES = 64,
  parameter int RD_LATENCY  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  hold,
  output logic                  mem_req,
  input  logic                  mem_gnt,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_valid,
  output logic                  wr_stop,
  output logic                  busy,
  output logic                  done
);

  localparam int CNT_W = ADDR_WIDTH + 2;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_ENTRIES - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_STOP  = 3'd4
  } state_t;

  state_t                state_r;
  logic [ADDR_WIDTH-1:0] next_addr_r;
  logic [RD_LATENCY-1:0] pipe_r;
  logic [CNT_W-1:0]      inflight_r;
  logic                  issue_s;
  logic                  pipe_out_s;
  logic                  drained_s;

  assign issue_s    = (state_r == ST_READ) && mem_gnt && !hold;
  assign pipe_out_s = pipe_r[RD_LATENCY-1];
  // Drained once every issued read has reached the writer and nothing is still in the RAM pipe.
  assign drained_s  = (inflight_r == {CNT_W{1'b0}}) && (pipe_r == {RD_LATENCY{1'b0}});

  // Read-data valid pipeline, matching the RAM latency; never stalled by hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_r <= {RD_LATENCY{1'b0}};
    end else begin
      pipe_r[0] <= mem_rd_en;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_r[i] <= pipe_r[i-1];
      end
    end
  end

  // Writer data path and count of reads issued but not yet handed to the writer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_data    <= {DATA_WIDTH{1'b0}};
      wr_valid   <= 1'b0;
      inflight_r <= {CNT_W{1'b0}};
    end else begin
      wr_valid <= pipe_out_s;
      if (pipe_out_s) begin
        wr_data <= mem_rdata;
      end
      case ({issue_s, pipe_out_s})
        2'b10:   inflight_r <= inflight_r + CNT_ONE;
        2'b01:   inflight_r <= inflight_r - CNT_ONE;
        default: inflight_r <= inflight_r;
      endcase
    end
  end

  // Dump sequencing FSM with registered port-request, read-strobe and stop outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      mem_req     <= 1'b0;
      mem_rd_en   <= 1'b0;
      mem_addr    <= {ADDR_WIDTH{1'b0}};
      next_addr_r <= {ADDR_WIDTH{1'b0}};
      wr_stop     <= 1'b0;
      done        <= 1'b0;
      busy        <= 1'b0;
    end else begin
      mem_rd_en <= issue_s;
      wr_stop   <= 1'b0;
      done      <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r     <= ST_REQ;
            mem_req     <= 1'b1;
            busy        <= 1'b1;
            mem_addr    <= {ADDR_WIDTH{1'b0}};
            next_addr_r <= {ADDR_WIDTH{1'b0}};
          end
        end
        ST_REQ: begin
          if (mem_gnt) begin
            state_r <= ST_READ;
          end
        end
        ST_READ: begin
          if (issue_s) begin
            // mem_addr shows the address being strobed; it parks on the last entry.
            mem_addr <= next_addr_r;
            if (next_addr_r == LAST_ADDR) begin
              state_r <= ST_DRAIN;
            end else begin
              next_addr_r <= next_addr_r + ADDR_ONE;
            end
          end
        end
        ST_DRAIN: begin
          if (drained_s) begin
            state_r <= ST_STOP;
            wr_stop <= 1'b1;
            done    <= 1'b1;
            mem_req <= 1'b0;
          end
        end
        ST_STOP: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          mem_req <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
